// File: rtl/mmio_input_conditioner.sv
// MMIO input conditioner: synchronises raw board inputs, debounces buttons,
// PMOD pins and the switch vector, and derives press flags / rise pulses.
module mmio_input_conditioner #(
  parameter int unsigned DB_COUNT = 1000000,
  parameter int unsigned CNT_W    = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] switch_array,
  input  logic [3:0]  button,
  input  logic [1:0]  pmod_pin,
  input  logic [3:0]  clr_press,
  output logic [15:0] sw_db,
  output logic [3:0]  btn_db,
  output logic [3:0]  btn_press,
  output logic [1:0]  pmod_db,
  output logic [1:0]  pmod_rise,
  output logic        any_press
);

  // Channels 0..3 are buttons, 4..5 are PMOD pins.
  localparam int unsigned NCH = 6;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_COUNT - 1);

  logic [21:0]      sync1_q, sync2_q;
  logic [NCH-1:0]   ch_in;
  logic [CNT_W-1:0] ch_cnt_q [NCH];
  logic [CNT_W-1:0] ch_cnt_d [NCH];
  logic [NCH-1:0]   ch_lvl_q, ch_lvl_d;
  logic [15:0]      sw_in;
  logic [15:0]      cand_q, cand_d;
  logic [15:0]      sw_db_q, sw_db_d;
  logic [CNT_W-1:0] sw_cnt_q, sw_cnt_d;
  logic [3:0]       press_q, press_d;
  logic [1:0]       rise_q, rise_d;

  assign sw_in = sync2_q[15:0];
  assign ch_in = sync2_q[21:16];

  // Two-flop synchroniser on every raw input bit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {pmod_pin, button, switch_array};
      sync2_q <= sync1_q;
    end
  end

  // Per-channel debounce: count while input differs from level, commit at the limit.
  always_comb begin
    ch_cnt_d = ch_cnt_q;
    ch_lvl_d = ch_lvl_q;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (ch_in[i] == ch_lvl_q[i]) begin
        ch_cnt_d[i] = '0;
      end else if (ch_cnt_q[i] == CNT_MAX) begin
        ch_lvl_d[i] = ch_in[i];
        ch_cnt_d[i] = '0;
      end else begin
        ch_cnt_d[i] = ch_cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Switch vector debounce: any bit change reloads the candidate and restarts
  // the shared count, so sw_db only ever takes a whole, stable vector.
  always_comb begin
    cand_d   = cand_q;
    sw_db_d  = sw_db_q;
    sw_cnt_d = '0;
    if (sw_in != cand_q) begin
      cand_d   = sw_in;
      sw_cnt_d = '0;
    end else if (sw_in != sw_db_q) begin
      if (sw_cnt_q == CNT_MAX) begin
        sw_db_d  = cand_q;
        sw_cnt_d = '0;
      end else begin
        sw_cnt_d = sw_cnt_q + CNT_W'(1);
      end
    end
  end

  // Sticky press flags (set beats clear) and one-cycle PMOD rise pulses.
  always_comb begin
    press_d = (ch_lvl_d[3:0] & ~ch_lvl_q[3:0]) | (press_q & ~clr_press);
    rise_d  = ch_lvl_d[5:4] & ~ch_lvl_q[5:4];
  end

  // State registers; reset overrides all other activity.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        ch_cnt_q[i] <= '0;
      end
      ch_lvl_q <= '0;
      cand_q   <= '0;
      sw_db_q  <= '0;
      sw_cnt_q <= '0;
      press_q  <= '0;
      rise_q   <= '0;
    end else begin
      ch_cnt_q <= ch_cnt_d;
      ch_lvl_q <= ch_lvl_d;
      cand_q   <= cand_d;
      sw_db_q  <= sw_db_d;
      sw_cnt_q <= sw_cnt_d;
      press_q  <= press_d;
      rise_q   <= rise_d;
    end
  end

  assign sw_db     = sw_db_q;
  assign btn_db    = ch_lvl_q[3:0];
  assign pmod_db   = ch_lvl_q[5:4];
  assign btn_press = press_q;
  assign pmod_rise = rise_q;
  assign any_press = |press_q;

endmodule

// File: tb/tb_mmio_input_conditioner.sv
// Randomised scoreboard bench for mmio_input_conditioner with a run-length
// reference model of the debounce behaviour.
module tb_mmio_input_conditioner;

  localparam int unsigned DB   = 8;
  localparam int          NCYC = 3000;

  logic        clk;
  logic        rst;
  logic [15:0] switch_array;
  logic [3:0]  button;
  logic [1:0]  pmod_pin;
  logic [3:0]  clr_press;
  logic [15:0] sw_db;
  logic [3:0]  btn_db;
  logic [3:0]  btn_press;
  logic [1:0]  pmod_db;
  logic [1:0]  pmod_rise;
  logic        any_press;

  mmio_input_conditioner #(.DB_COUNT(DB), .CNT_W(24)) dut (
    .clk(clk), .rst(rst), .switch_array(switch_array), .button(button),
    .pmod_pin(pmod_pin), .clr_press(clr_press), .sw_db(sw_db), .btn_db(btn_db),
    .btn_press(btn_press), .pmod_db(pmod_db), .pmod_rise(pmod_rise),
    .any_press(any_press)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [15:0] sw;
    logic [3:0]  bdb;
    logic [3:0]  bp;
    logic [1:0]  pdb;
    logic [1:0]  pr;
    logic        ap;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  bit   stim_done = 1'b0;

  // Reference model: values seen after the synchroniser, run lengths of
  // unchanged values, and the expected output state.
  logic [21:0] m_s1, m_s2;
  logic [15:0] m_sw_run_val;
  int          m_sw_run;
  logic [5:0]  m_ch_run_val;
  int          m_ch_run [6];
  logic [15:0] m_sw;
  logic [5:0]  m_lvl;
  logic [3:0]  m_press;
  logic [1:0]  m_rise;

  // Advance the model across one rising edge using the currently driven inputs.
  function automatic void model_step();
    logic [5:0] ch;
    logic [5:0] nl;
    exp_t e;
    if (!rst) begin
      m_s1 = '0; m_s2 = '0;
      m_sw_run_val = '0; m_sw_run = 1;
      m_ch_run_val = '0;
      foreach (m_ch_run[i]) m_ch_run[i] = 1;
      m_sw = '0; m_lvl = '0; m_press = '0; m_rise = '0;
    end else begin
      // Switches commit once the vector has been seen unchanged on DB+1 edges.
      if (m_s2[15:0] == m_sw_run_val) begin
        if (m_sw_run < 100000) m_sw_run++;
      end else begin
        m_sw_run = 1;
        m_sw_run_val = m_s2[15:0];
      end
      if (m_sw_run_val != m_sw && m_sw_run == int'(DB) + 1) m_sw = m_sw_run_val;
      // Single channels flip once the opposite value has been seen on DB edges.
      ch = m_s2[21:16];
      nl = m_lvl;
      for (int i = 0; i < 6; i++) begin
        if (ch[i] == m_ch_run_val[i]) begin
          if (m_ch_run[i] < 100000) m_ch_run[i]++;
        end else begin
          m_ch_run[i] = 1;
          m_ch_run_val[i] = ch[i];
        end
        if (ch[i] != m_lvl[i] && m_ch_run[i] >= int'(DB)) nl[i] = ch[i];
      end
      m_press = (nl[3:0] & ~m_lvl[3:0]) | (m_press & ~clr_press);
      m_rise  = nl[5:4] & ~m_lvl[5:4];
      m_lvl   = nl;
      m_s2 = m_s1;
      m_s1 = {pmod_pin, button, switch_array};
    end
    e.sw  = m_sw;
    e.bdb = m_lvl[3:0];
    e.bp  = m_press;
    e.pdb = m_lvl[5:4];
    e.pr  = m_rise;
    e.ap  = |m_press;
    exp_q.push_back(e);
  endfunction

  task automatic drive_next(input int c);
    int r;
    rst = (c < 4) ? 1'b0 : (($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1);
    for (int i = 0; i < 4; i++)
      if ($urandom_range(0, 13) == 0) button[i] = ~button[i];
    for (int i = 0; i < 2; i++)
      if ($urandom_range(0, 13) == 0) pmod_pin[i] = ~pmod_pin[i];
    r = int'($urandom_range(0, 29));
    if (r == 0) switch_array = 16'($urandom);
    else if (r == 1) switch_array[$urandom_range(0, 15)] = ~switch_array[$urandom_range(0, 15)];
    else if (r == 2) switch_array[0] = ~switch_array[0];
    for (int i = 0; i < 4; i++)
      clr_press[i] = ($urandom_range(0, 5) == 0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, act, want);
    end
  endtask

  // Monitor: pops one expected record per rising edge and compares all outputs.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #3;
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sw_db",     32'(sw_db),     32'(e.sw));
        chk("btn_db",    32'(btn_db),    32'(e.bdb));
        chk("btn_press", 32'(btn_press), 32'(e.bp));
        chk("pmod_db",   32'(pmod_db),   32'(e.pdb));
        chk("pmod_rise", 32'(pmod_rise), 32'(e.pr));
        chk("any_press", 32'(any_press), 32'(e.ap));
      end else if (!stim_done) begin
        total++;
        bad++;
        $display("FAIL scoreboard_underflow cycle=%0d got=empty want=record", cyc);
      end
    end
  end

  // Stimulus: random input activity with occasional resets.
  initial begin
    rst = 1'b0;
    switch_array = '0;
    button = '0;
    pmod_pin = '0;
    clr_press = '0;
    model_step();
    for (int c = 1; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      drive_next(c);
      model_step();
    end
    @(posedge clk);
    #1;
    stim_done = 1'b1;
    repeat (3) @(posedge clk);
    #5;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
